spike_event_fifo: RTL and testbench



---
 rtl/spike_event_fifo.sv | 100 ++++++++++
 tb/tb_spike_event_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: timestamps neuron spike events and buffers them in a
// small FIFO drained over a valid/ready interface. Dropped events are
// counted (saturating) and flagged with a sticky overflow bit.
//
// Build option: define SPIKE_EDGE_EN to log only rising edges of spike.
// Without it, every cycle with spike high is an event.
module spike_event_fifo #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       spike,
   input  logic [7:0]                 state_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [TS_W+7:0]            out_data,
   output logic [$clog2(DEPTH):0]     fill,
   output logic                       overflow,
   output logic [7:0]                 drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

   logic [TS_W-1:0]    ts;
   logic [TS_W+7:0]    mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               event_hit;
   logic               pop;
   logic               push;
   logic               drop;

`ifdef SPIKE_EDGE_EN
   logic spike_q;

   // Previous-cycle copy of spike for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) spike_q <= 1'b0;
      else     spike_q <= spike;
   end

   assign event_hit = spike & ~spike_q;
`else
   assign event_hit = spike;
`endif

   assign out_valid = (fill != '0);
   assign pop       = out_valid & out_ready;
   // A full FIFO can still accept an event when the head leaves this cycle.
   assign push      = event_hit & ((fill != FULL_CNT) | pop);
   assign drop      = event_hit & (fill == FULL_CNT) & ~pop;
   assign out_data  = mem[rd_ptr];

   // Free-running timestamp, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) ts <= '0;
      else     ts <= ts + TS_W'(1);
   end

   // Event storage; cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= {ts, state_in};
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fill <= fill + FW'(1);
            2'b01:   fill <= fill - FW'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Sticky overflow and saturating drop counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_spike_event_fifo.sv
// Testbench for spike_event_fifo (DEPTH=8, TS_W=8) against a queue-based
// reference model. Honours SPIKE_EDGE_EN when defined.
module tb_spike_event_fifo;

   localparam int DEPTH = 8;
   localparam int TS_W  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        spike;
   logic [7:0]  state_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  fill;
   logic        overflow;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] q[$];
   logic [7:0]  m_ts;
   logic        m_prev;
   logic        m_ovf;
   int          m_drop;

   spike_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk(clk), .rst(rst), .spike(spike), .state_in(state_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fill(fill), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("fill", 32'(fill), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
   endtask

   // One clock cycle, entered and left at a negedge.
   task automatic cyc(input logic s, input logic [7:0] st, input logic rdy);
      logic ev, mpop, was_full;
      spike = s; state_in = st; out_ready = rdy;
`ifdef SPIKE_EDGE_EN
      ev = s && !m_prev;
`else
      ev = s;
`endif
      mpop = (q.size() != 0) && rdy;
      was_full = (q.size() == DEPTH);
      if (mpop) void'(q.pop_front());
      if (ev) begin
         if (!was_full || mpop) q.push_back({m_ts, st});
         else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
         end
      end
      m_prev = s;
      m_ts = m_ts + 8'd1;
      @(posedge clk);
      @(negedge clk);
      chk_model();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      spike = 1'b1; state_in = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b0; spike = 1'b0; out_ready = 1'b0;
      q.delete();
      m_ts = 8'd0; m_prev = 1'b0; m_ovf = 1'b0; m_drop = 0;
      chk_model();
   endtask

   int held;

   initial begin
      rst = 1'b1; spike = 1'b0; state_in = 8'h00; out_ready = 1'b0;
      @(negedge clk);

      // 1. reset values
      do_reset(2);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst fill", 32'(fill), 32'd0);
      chk("rst out_data", 32'(out_data), 32'd0);

      // 2. single event at ts=5
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h2A, 1'b0);
      chk("single out_valid", 32'(out_valid), 32'd1);
      chk("single out_data", 32'(out_data), 32'h052A);
      chk("single fill", 32'(fill), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);
      chk("single drained fill", 32'(fill), 32'd0);
      chk("single drained valid", 32'(out_valid), 32'd0);

      // 3. overflow: 11 separate spikes with no consumer
      for (int i = 0; i < 11; i++) begin
         cyc(1'b1, 8'(8'h10 + i), 1'b0);
         cyc(1'b0, 8'h00, 1'b0);
      end
      chk("ovf fill", 32'(fill), 32'd8);
      chk("ovf flag", 32'(overflow), 32'd1);
      chk("ovf drop_count", 32'(drop_count), 32'd3);
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

      // 4. full with simultaneous pop
      do_reset(1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 8'(8'h40 + i), 1'b0);
         cyc(1'b0, 8'h00, 1'b0);
      end
      cyc(1'b1, 8'h77, 1'b1);
      chk("fullpop fill", 32'(fill), 32'd8);
      chk("fullpop drop_count", 32'(drop_count), 32'd0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1);
      chk("fullpop last data", 32'(out_data[7:0]), 32'h77);
      cyc(1'b0, 8'h00, 1'b1);

      // 5a. 300 random cycles: timestamp wraps past 255
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

      // 5b. keep full, drop 260+ events: counter saturates
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 8'($urandom), 1'b0);
         cyc(1'b0, 8'h00, 1'b0);
      end
      for (int i = 0; i < 270; i++) begin
         cyc(1'b1, 8'($urandom), 1'b0);
         cyc(1'b0, 8'h00, 1'b0);
      end
      chk("sat drop_count", 32'(drop_count), 32'd255);
      chk("sat overflow", 32'(overflow), 32'd1);

      // 6a. spike held high for 4 cycles
      do_reset(1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
`ifdef SPIKE_EDGE_EN
      held = 1;
`else
      held = 4;
`endif
      chk("held fill", 32'(fill), 32'(held));

      // 6b. reset mid-drain with fill = 5
      while (q.size() < 5) begin
         cyc(1'b1, 8'($urandom), 1'b0);
         cyc(1'b0, 8'h00, 1'b0);
      end
      chk("pre-reset fill", 32'(fill), 32'd5);
      cyc(1'b0, 8'h00, 1'b1);
      do_reset(1);
      chk("mid-drain fill", 32'(fill), 32'd0);
      chk("mid-drain valid", 32'(out_valid), 32'd0);

      // random soak
      for (int i = 0; i < 2000; i++)
         cyc(1'($urandom_range(0, 99) < 50), 8'($urandom),
             1'($urandom_range(0, 99) < 40));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
